// File: rtl/gray_ptr_sync.sv
// ============================================================================
// Module   : gray_ptr_sync
// Purpose  : Multi-stage clock-domain-crossing synchroniser for Gray-coded
//            FIFO pointers. Re-times a foreign-domain Gray pointer through
//            STAGES flops and converts it to binary. Also produces an update
//            pulse and the pointer advance since the previous update, so that
//            full/empty/level logic needs no local subtractor.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   ADDR_WIDTH : FIFO address width; pointer width PW = ADDR_WIDTH + 1
//   STAGES     : synchroniser depth, 2..4 (anything else fails elaboration)
//   RESET_VAL  : Gray reset value of every synchroniser stage (PW bits)
// Ports:
//   clk         in   1   local-domain clock, rising edge
//   rst         in   1   asynchronous active-high reset
//   async_gray  in   PW  Gray pointer from the foreign domain
//   err_clr     in   1   synchronous clear of gray_err
//   sync_gray   out  PW  last synchroniser stage
//   sync_bin    out  PW  registered binary equivalent of sync_gray
//   ptr_changed out  1   one-cycle pulse when sync_bin takes a new value
//   ptr_delta   out  PW  (new sync_bin - previous sync_bin) mod 2^PW
//   gray_err    out  1   sticky "more than one Gray bit changed" flag
// Optional feature:
//   GRAY_PTR_SYNC_CHECK_EN : when defined, compiles in the Gray coherence
//                            checker; otherwise gray_err is tied low.
// ============================================================================
`default_nettype none

module gray_ptr_sync #(
    parameter int                  ADDR_WIDTH = 4,
    parameter int                  STAGES     = 2,
    parameter logic [ADDR_WIDTH:0] RESET_VAL  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH:0]   async_gray,
    input  logic                  err_clr,
    output logic [ADDR_WIDTH:0]   sync_gray,
    output logic [ADDR_WIDTH:0]   sync_bin,
    output logic                  ptr_changed,
    output logic [ADDR_WIDTH:0]   ptr_delta,
    output logic                  gray_err
);

    localparam int PW = ADDR_WIDTH + 1;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    localparam logic [PW-1:0] C_BIN_RST = gray2bin(RESET_VAL);

    generate
        if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
            $error("gray_ptr_sync: STAGES must be in 2..4");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Synchroniser chain. Each stage carries the whole pointer; because only
    // one Gray bit moves per foreign clock, a metastable first stage can only
    // settle to the old or the new pointer, never a blend of the two.
    // ------------------------------------------------------------------------
    logic [PW-1:0] r_stage [STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stage[0] <= RESET_VAL;
        end else begin
            r_stage[0] <= async_gray;
        end
    end

    generate
        for (genvar g = 1; g < STAGES; g++) begin : g_stage
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_stage[g] <= RESET_VAL;
                end else begin
                    r_stage[g] <= r_stage[g-1];
                end
            end
        end
    endgenerate

    assign sync_gray = r_stage[STAGES-1];

    // ------------------------------------------------------------------------
    // Binary conversion and change tracking. r_prev lags sync_gray by one
    // cycle, so a change is seen exactly once per distinct synchronised value
    // and lines up with the cycle in which r_bin picks up the new value.
    // ------------------------------------------------------------------------
    logic [PW-1:0] w_bin;
    logic          w_change;
    logic [PW-1:0] r_prev;
    logic [PW-1:0] r_bin;
    logic          r_changed;
    logic [PW-1:0] r_delta;

    assign w_bin    = gray2bin(sync_gray);
    assign w_change = (sync_gray != r_prev);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev    <= RESET_VAL;
            r_bin     <= C_BIN_RST;
            r_changed <= 1'b0;
            r_delta   <= '0;
        end else begin
            r_prev    <= sync_gray;
            r_bin     <= w_bin;
            r_changed <= w_change;
            // Modulo-2^PW subtraction: a wrap (e.g. 31 -> 0) yields a small
            // positive advance rather than a negative number.
            r_delta   <= w_change ? (w_bin - r_bin) : '0;
        end
    end

    assign sync_bin    = r_bin;
    assign ptr_changed = r_changed;
    assign ptr_delta   = r_delta;

`ifdef GRAY_PTR_SYNC_CHECK_EN
    // ------------------------------------------------------------------------
    // Coherence checker: count the bits that moved between consecutive
    // synchronised values; more than one means the foreign side broke the
    // Gray discipline (or the crossing is unconstrained).
    // ------------------------------------------------------------------------
    logic [PW-1:0] w_diff;
    logic [7:0]    w_ones;
    logic          w_multi;
    logic          r_err;

    assign w_diff = sync_gray ^ r_prev;

    always_comb begin
        w_ones = 8'd0;
        for (int i = 0; i < PW; i++) begin
            w_ones = w_ones + {7'd0, w_diff[i]};
        end
        w_multi = (w_ones > 8'd1);
    end

    // Set has priority over clear so a fresh error is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_multi) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign gray_err = r_err;
`else
    logic w_unused_err_clr;
    assign w_unused_err_clr = err_clr;
    assign gray_err         = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gray_ptr_sync.sv
// ============================================================================
// Module   : tb_gray_ptr_sync
// Purpose  : Directed self-checking bench for gray_ptr_sync. Two instances
//            (STAGES=2 and STAGES=3) share the same stimulus so the latency
//            difference can be checked side by side. Expected gray_err
//            behaviour follows whether GRAY_PTR_SYNC_CHECK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gray_ptr_sync;

    localparam int PW = 5;
`ifdef GRAY_PTR_SYNC_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          err_clr;
    logic [PW-1:0] async_gray;

    logic [PW-1:0] s2_gray, s2_bin, s2_delta;
    logic          s2_chg, s2_err;
    logic [PW-1:0] s3_gray, s3_bin, s3_delta;
    logic          s3_chg, s3_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    gray_ptr_sync #(.ADDR_WIDTH(4), .STAGES(2), .RESET_VAL(5'd0)) u_s2 (
        .clk(clk), .rst(rst), .async_gray(async_gray), .err_clr(err_clr),
        .sync_gray(s2_gray), .sync_bin(s2_bin), .ptr_changed(s2_chg),
        .ptr_delta(s2_delta), .gray_err(s2_err)
    );

    gray_ptr_sync #(.ADDR_WIDTH(4), .STAGES(3), .RESET_VAL(5'd0)) u_s3 (
        .clk(clk), .rst(rst), .async_gray(async_gray), .err_clr(err_clr),
        .sync_gray(s3_gray), .sync_bin(s3_bin), .ptr_changed(s3_chg),
        .ptr_delta(s3_delta), .gray_err(s3_err)
    );

    // Advance one clock and sample just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; async_gray = 5'b00110;
        tick();
        n_cmp++; if (s2_gray  !== 5'd0) begin n_bad++; $display("FAIL rst_gray: got %0d want 0", s2_gray);  end
        n_cmp++; if (s2_bin   !== 5'd0) begin n_bad++; $display("FAIL rst_bin: got %0d want 0", s2_bin);    end
        n_cmp++; if (s2_chg   !== 1'b0) begin n_bad++; $display("FAIL rst_chg: got %0b want 0", s2_chg);    end
        n_cmp++; if (s2_delta !== 5'd0) begin n_bad++; $display("FAIL rst_delta: got %0d want 0", s2_delta); end
        n_cmp++; if (s2_err   !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %0b want 0", s2_err);    end
        n_cmp++; if (s3_gray  !== 5'd0) begin n_bad++; $display("FAIL rst_gray3: got %0d want 0", s3_gray); end
        rst = 1'b0;
        tick(); // s[0] captures 00110
        n_cmp++; if (s2_gray !== 5'd0) begin n_bad++; $display("FAIL rel_gray_e1: got %0d want 0", s2_gray); end
        tick(); // sync_gray now 00110
        n_cmp++; if (s2_gray !== 5'b00110) begin n_bad++; $display("FAIL rel_gray_e2: got %0d want 6", s2_gray); end
        n_cmp++; if (s2_chg  !== 1'b0)     begin n_bad++; $display("FAIL rel_chg_e2: got %0b want 0", s2_chg);  end
        tick();
        n_cmp++; if (s2_bin   !== 5'd4) begin n_bad++; $display("FAIL rel_bin: got %0d want 4", s2_bin);     end
        n_cmp++; if (s2_chg   !== 1'b1) begin n_bad++; $display("FAIL rel_chg: got %0b want 1", s2_chg);     end
        n_cmp++; if (s2_delta !== 5'd4) begin n_bad++; $display("FAIL rel_delta: got %0d want 4", s2_delta); end
        n_cmp++; if (s3_gray  !== 5'b00110) begin n_bad++; $display("FAIL rel_gray3: got %0d want 6", s3_gray); end
        tick();
        n_cmp++; if (s2_chg   !== 1'b0) begin n_bad++; $display("FAIL rel_chg_off: got %0b want 0", s2_chg);     end
        n_cmp++; if (s2_delta !== 5'd0) begin n_bad++; $display("FAIL rel_delta_off: got %0d want 0", s2_delta); end
        n_cmp++; if (s3_bin   !== 5'd4) begin n_bad++; $display("FAIL rel_bin3: got %0d want 4", s3_bin);         end
        n_cmp++; if (s3_chg   !== 1'b1) begin n_bad++; $display("FAIL rel_chg3: got %0b want 1", s3_chg);         end
        n_cmp++; if (s3_delta !== 5'd4) begin n_bad++; $display("FAIL rel_delta3: got %0d want 4", s3_delta);     end
        tick();
        n_cmp++; if (s3_chg !== 1'b0) begin n_bad++; $display("FAIL rel_chg3_off: got %0b want 0", s3_chg); end
    endtask

    task automatic test_latency();
        rst = 1'b1; async_gray = 5'd0;
        tick();
        rst = 1'b0;
        tick(); tick(); tick();
        async_gray = 5'd1;
        tick(); // edge 0
        n_cmp++; if (s2_gray !== 5'd0) begin n_bad++; $display("FAIL lat_e0_gray: got %0d want 0", s2_gray); end
        tick(); // edge 1
        n_cmp++; if (s2_gray !== 5'd1) begin n_bad++; $display("FAIL lat_e1_gray: got %0d want 1", s2_gray);  end
        n_cmp++; if (s2_chg  !== 1'b0) begin n_bad++; $display("FAIL lat_e1_chg: got %0b want 0", s2_chg);    end
        n_cmp++; if (s3_gray !== 5'd0) begin n_bad++; $display("FAIL lat_e1_gray3: got %0d want 0", s3_gray); end
        tick(); // edge 2
        n_cmp++; if (s2_bin   !== 5'd1) begin n_bad++; $display("FAIL lat_e2_bin: got %0d want 1", s2_bin);     end
        n_cmp++; if (s2_chg   !== 1'b1) begin n_bad++; $display("FAIL lat_e2_chg: got %0b want 1", s2_chg);     end
        n_cmp++; if (s2_delta !== 5'd1) begin n_bad++; $display("FAIL lat_e2_delta: got %0d want 1", s2_delta); end
        n_cmp++; if (s3_gray  !== 5'd1) begin n_bad++; $display("FAIL lat_e2_gray3: got %0d want 1", s3_gray);  end
        n_cmp++; if (s3_chg   !== 1'b0) begin n_bad++; $display("FAIL lat_e2_chg3: got %0b want 0", s3_chg);    end
        tick(); // edge 3
        n_cmp++; if (s2_chg   !== 1'b0) begin n_bad++; $display("FAIL lat_e3_chg: got %0b want 0", s2_chg);      end
        n_cmp++; if (s3_bin   !== 5'd1) begin n_bad++; $display("FAIL lat_e3_bin3: got %0d want 1", s3_bin);     end
        n_cmp++; if (s3_chg   !== 1'b1) begin n_bad++; $display("FAIL lat_e3_chg3: got %0b want 1", s3_chg);     end
        n_cmp++; if (s3_delta !== 5'd1) begin n_bad++; $display("FAIL lat_e3_delta3: got %0d want 1", s3_delta); end
        tick(); // edge 4
        n_cmp++; if (s3_chg !== 1'b0) begin n_bad++; $display("FAIL lat_e4_chg3: got %0b want 0", s3_chg); end
    endtask

    // Starts at bin 1; walks bin 30 -> 31 -> 0, holding each Gray value 4 cycles.
    task automatic test_wrap();
        logic [PW-1:0] seq_g [3];
        logic [PW-1:0] exp_b [3];
        logic [PW-1:0] exp_d [3];
        int            pulses;
        logic [PW-1:0] got_b, got_d;
        seq_g = '{5'b10001, 5'b10000, 5'b00000};
        exp_b = '{5'd30,    5'd31,    5'd0};
        exp_d = '{5'd29,    5'd1,     5'd1};
        for (int k = 0; k < 3; k++) begin
            async_gray = seq_g[k];
            pulses = 0; got_b = 'x; got_d = 'x;
            for (int c = 0; c < 4; c++) begin
                tick();
                if (s2_chg === 1'b1) begin
                    pulses++; got_b = s2_bin; got_d = s2_delta;
                end
            end
            n_cmp++; if (pulses !== 1)        begin n_bad++; $display("FAIL wrap_pulses[%0d]: got %0d want 1", k, pulses);          end
            n_cmp++; if (got_b  !== exp_b[k]) begin n_bad++; $display("FAIL wrap_bin[%0d]: got %0d want %0d", k, got_b, exp_b[k]);   end
            n_cmp++; if (got_d  !== exp_d[k]) begin n_bad++; $display("FAIL wrap_delta[%0d]: got %0d want %0d", k, got_d, exp_d[k]); end
        end
    endtask

    // Starts at bin 0; parks at bin 31 so that bin 0..7 yields eight pulses.
    task automatic test_back_to_back();
        int p2, p3, bad2;
        logic [PW-1:0] b;
        async_gray = 5'b10000;
        for (int c = 0; c < 5; c++) tick();
        p2 = 0; p3 = 0; bad2 = 0;
        for (int c = 0; c < 13; c++) begin
            if (c < 8) begin
                b = c[PW-1:0];
                async_gray = b ^ (b >> 1);
            end
            tick();
            if (s2_chg === 1'b1) begin
                p2++;
                if (s2_delta !== 5'd1) bad2++;
            end
            if (s3_chg === 1'b1) p3++;
        end
        n_cmp++; if (p2     !== 8)    begin n_bad++; $display("FAIL burst_pulses: got %0d want 8", p2);      end
        n_cmp++; if (bad2   !== 0)    begin n_bad++; $display("FAIL burst_delta: got %0d bad want 0", bad2); end
        n_cmp++; if (p3     !== 8)    begin n_bad++; $display("FAIL burst_pulses3: got %0d want 8", p3);     end
        n_cmp++; if (s2_bin !== 5'd7) begin n_bad++; $display("FAIL burst_bin: got %0d want 7", s2_bin);     end
        n_cmp++; if (s3_bin !== 5'd7) begin n_bad++; $display("FAIL burst_bin3: got %0d want 7", s3_bin);    end
        n_cmp++; if (s2_err !== 1'b0) begin n_bad++; $display("FAIL burst_err: got %0b want 0", s2_err);     end
    endtask

    task automatic test_checker();
        rst = 1'b1; async_gray = 5'd0;
        tick();
        rst = 1'b0;
        tick(); tick(); tick();
        async_gray = 5'b00011; // two bits move at once
        tick(); tick();
        n_cmp++; if (s2_err !== 1'b0) begin n_bad++; $display("FAIL chk_pre: got %0b want 0", s2_err); end
        tick();
        n_cmp++; if (s2_chg   !== 1'b1) begin n_bad++; $display("FAIL chk_chg: got %0b want 1", s2_chg);        end
        n_cmp++; if (s2_delta !== 5'd2) begin n_bad++; $display("FAIL chk_delta: got %0d want 2", s2_delta);    end
        n_cmp++; if (s2_err   !== CHK)  begin n_bad++; $display("FAIL chk_set: got %0b want %0b", s2_err, CHK); end
        tick(); tick();
        n_cmp++; if (s2_err !== CHK) begin n_bad++; $display("FAIL chk_sticky: got %0b want %0b", s2_err, CHK); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_cmp++; if (s2_err !== 1'b0) begin n_bad++; $display("FAIL chk_clr: got %0b want 0", s2_err); end
        // New two-bit error arriving while err_clr is held: set must win.
        async_gray = 5'b00000; err_clr = 1'b1;
        tick(); tick(); tick();
        n_cmp++; if (s2_chg   !== 1'b1)  begin n_bad++; $display("FAIL chk2_chg: got %0b want 1", s2_chg);           end
        n_cmp++; if (s2_delta !== 5'd30) begin n_bad++; $display("FAIL chk2_delta: got %0d want 30", s2_delta);      end
        n_cmp++; if (s2_err   !== CHK)   begin n_bad++; $display("FAIL chk2_setwins: got %0b want %0b", s2_err, CHK); end
        err_clr = 1'b0;
        tick();
        n_cmp++; if (s2_err !== CHK) begin n_bad++; $display("FAIL chk2_hold: got %0b want %0b", s2_err, CHK); end
    endtask

    task automatic test_midrun_reset();
        int p;
        async_gray = 5'b00001;
        tick(); tick(); tick();
        n_cmp++; if (s2_chg !== 1'b1) begin n_bad++; $display("FAIL mid_pre_chg: got %0b want 1", s2_chg); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (s2_gray  !== 5'd0) begin n_bad++; $display("FAIL mid_gray: got %0d want 0", s2_gray);   end
        n_cmp++; if (s2_bin   !== 5'd0) begin n_bad++; $display("FAIL mid_bin: got %0d want 0", s2_bin);     end
        n_cmp++; if (s2_chg   !== 1'b0) begin n_bad++; $display("FAIL mid_chg: got %0b want 0", s2_chg);     end
        n_cmp++; if (s2_delta !== 5'd0) begin n_bad++; $display("FAIL mid_delta: got %0d want 0", s2_delta); end
        n_cmp++; if (s2_err   !== 1'b0) begin n_bad++; $display("FAIL mid_err: got %0b want 0", s2_err);     end
        n_cmp++; if (s3_gray  !== 5'd0) begin n_bad++; $display("FAIL mid_gray3: got %0d want 0", s3_gray);  end
        async_gray = 5'd0;
        tick();
        rst = 1'b0;
        p = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (s2_chg === 1'b1) p++;
        end
        n_cmp++; if (p !== 0) begin n_bad++; $display("FAIL mid_post_pulses: got %0d want 0", p); end
    endtask

    initial begin
        rst = 1'b1; err_clr = 1'b0; async_gray = 5'd0;
        test_reset();
        test_latency();
        test_wrap();
        test_back_to_back();
        test_checker();
        test_midrun_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
